// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller and the pipeline top.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

  // Controller state: normal issue, or frozen on an outstanding data access
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  // Register index that never carries a dependency (x0)
  localparam int REG_ZERO = 0;

  // Stall/flush bundle driven into the pipeline registers
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hz_ctrl_t;

  // Bundle with every stall and flush released
  function automatic hz_ctrl_t hz_ctrl_idle();
    return '0;
  endfunction

  // Bundle that freezes F..M and bubbles W while memory is busy
  function automatic hz_ctrl_t hz_ctrl_mem_freeze();
    hz_ctrl_t c;
    c         = '0;
    c.stall_f = 1'b1;
    c.stall_d = 1'b1;
    c.stall_e = 1'b1;
    c.stall_m = 1'b1;
    c.flush_w = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// Latency: n/a (wiring only).
// Backpressure: n/a; stall/flush lines are the flow control themselves.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] rs1_d;
  logic [REG_W-1:0] rs2_d;
  logic [REG_W-1:0] rd_e;
  logic             memread_e;
  logic             redirect_e;
  logic             mem_req_m;
  logic             mem_ready_m;

  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic             flush_w;
  logic             ctrl_stall;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_err;

  // Pipeline side: presents stage info, consumes stall/flush
  modport master (
    output rs1_d, rs2_d, rd_e, memread_e, redirect_e, mem_req_m, mem_ready_m,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
    input  ctrl_stall, stall_cnt, mem_err
  );

  // Controller side
  modport slave (
    input  rs1_d, rs2_d, rd_e, memread_e, redirect_e, mem_req_m, mem_ready_m,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
    output ctrl_stall, stall_cnt, mem_err
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in E and the sources of D.
// Latency: purely combinational, same cycle.
// Backpressure: none; result feeds the controller priority logic.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic             memread_i,
  output logic             lu_hz_o
);

  // A load writing x0 produces nothing to wait for
  always_comb begin
    lu_hz_o = memread_i && (rd_i != REG_W'(REG_ZERO)) &&
              ((rd_i == rs1_i) || (rd_i == rs2_i));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubble, redirect flush, freeze on slow memory.
// Latency: stall/flush are combinational from state + inputs; counters update on clk.
// Backpressure: mem_ready_m low holds F..M frozen and bubbles W until it completes.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam int  WAIT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit  TIMEOUT_EN = (MEM_TIMEOUT != 0);

  hz_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic              lu_hz;
  logic              mem_busy;
  hz_ctrl_t          ctrl;

  hazard_detect #(.REG_W(REG_W)) u_detect (
    .rs1_i     (hz.rs1_d),
    .rs2_i     (hz.rs2_d),
    .rd_i      (hz.rd_e),
    .memread_i (hz.memread_e),
    .lu_hz_o   (lu_hz)
  );

  assign mem_busy = hz.mem_req_m && !hz.mem_ready_m;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state: enter the wait on a stalled access, leave once it completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (mem_busy)       state_d = MEM_WAIT;
      MEM_WAIT: if (hz.mem_ready_m) state_d = RUN;
      default:                      state_d = RUN;
    endcase
  end

  // Outputs: in MEM_WAIT E is frozen, so redirect and load-use wait until exit
  always_comb begin
    ctrl = hz_ctrl_idle();
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          ctrl = hz_ctrl_mem_freeze();
        end else if (hz.redirect_e) begin
          // wrong-path D instruction; any load-use against it is moot
          ctrl.flush_d = 1'b1;
          ctrl.flush_e = 1'b1;
        end else if (lu_hz) begin
          ctrl.stall_f = 1'b1;
          ctrl.stall_d = 1'b1;
          ctrl.flush_e = 1'b1;
        end
      end
      MEM_WAIT: ctrl = hz_ctrl_mem_freeze();
      default:  ctrl = hz_ctrl_idle();
    endcase
  end

  // Counter next-state: wait age, saturating stall count, sticky timeout
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    mem_err_d   = mem_err_q;
    if (ctrl.stall_f && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (state_q == RUN) begin
      if (mem_busy) wait_cnt_d = WAIT_W'(1);
    end else begin
      if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
      if (TIMEOUT_EN && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT))) mem_err_d = 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign hz.stall_f    = ctrl.stall_f;
  assign hz.stall_d    = ctrl.stall_d;
  assign hz.stall_e    = ctrl.stall_e;
  assign hz.stall_m    = ctrl.stall_m;
  assign hz.flush_d    = ctrl.flush_d;
  assign hz.flush_e    = ctrl.flush_e;
  assign hz.flush_w    = ctrl.flush_w;
  assign hz.ctrl_stall = ctrl.flush_e;
  assign hz.stall_cnt  = stall_cnt_q;
  assign hz.mem_err    = mem_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (default and short timeout / narrow counter).
// Latency: stimulus applied 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: exercised through mem_req_m / mem_ready_m directed vectors.
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       memread, redirect, req, ready;

  int n_chk  = 0;
  int n_fail = 0;

  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) ifa ();
  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(2))  ifb ();

  assign ifa.rs1_d = rs1;       assign ifb.rs1_d = rs1;
  assign ifa.rs2_d = rs2;       assign ifb.rs2_d = rs2;
  assign ifa.rd_e = rd;         assign ifb.rd_e = rd;
  assign ifa.memread_e = memread;   assign ifb.memread_e = memread;
  assign ifa.redirect_e = redirect; assign ifb.redirect_e = redirect;
  assign ifa.mem_req_m = req;       assign ifb.mem_req_m = req;
  assign ifa.mem_ready_m = ready;   assign ifb.mem_ready_m = ready;

  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(16), .MEM_TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst), .hz(ifa)
  );
  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(2), .MEM_TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .hz(ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  // Per instance: are we waiting on memory, how many cycles the access has
  // been outstanding, stall-cycle total and sticky error.
  int TO   [2] = '{255, 4};
  int CMAX [2] = '{65535, 3};
  bit m_wait [2] = '{0, 0};
  int m_age  [2] = '{0, 0};
  int m_scnt [2] = '{0, 0};
  bit m_err  [2] = '{0, 0};

  // Expected {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_w,ctrl_stall}
  function automatic logic [7:0] model_ctrl(input bit waiting);
    bit lu;
    lu = memread && (rd != 0) && (rd == rs1 || rd == rs2);
    if (waiting || (req && !ready)) return 8'b1111_0010;
    if (redirect)                   return 8'b0000_1101;
    if (lu)                         return 8'b1100_0101;
    return 8'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_wait[i] <= 1'b0;
        m_age[i]  <= 0;
        m_scnt[i] <= 0;
        m_err[i]  <= 1'b0;
      end else begin
        if (model_ctrl(m_wait[i]) & 8'h80) begin
          if (m_scnt[i] < CMAX[i]) m_scnt[i] <= m_scnt[i] + 1;
        end
        if (m_wait[i]) begin
          if (TO[i] != 0 && m_age[i] >= TO[i]) m_err[i] <= 1'b1;
          m_age[i] <= m_age[i] + 1;
          if (ready) m_wait[i] <= 1'b0;
        end else if (req && !ready) begin
          m_wait[i] <= 1'b1;
          m_age[i]  <= 1;
        end
      end
    end
  end

  function automatic logic [7:0] dut_ctrl(input int idx);
    if (idx == 0)
      return {ifa.stall_f, ifa.stall_d, ifa.stall_e, ifa.stall_m,
              ifa.flush_d, ifa.flush_e, ifa.flush_w, ifa.ctrl_stall};
    return {ifb.stall_f, ifb.stall_d, ifb.stall_e, ifb.stall_m,
            ifb.flush_d, ifb.flush_e, ifb.flush_w, ifb.ctrl_stall};
  endfunction

  function automatic logic [31:0] dut_cnt(input int idx);
    if (idx == 0) return 32'(ifa.stall_cnt);
    return 32'(ifb.stall_cnt);
  endfunction

  function automatic logic dut_err(input int idx);
    if (idx == 0) return ifa.mem_err;
    return ifb.mem_err;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model_ctrl[%0d]", i), 32'(dut_ctrl(i)), 32'(model_ctrl(m_wait[i])));
      chk($sformatf("model_cnt[%0d]", i), dut_cnt(i), 32'(m_scnt[i]));
      chk($sformatf("model_err[%0d]", i), 32'(dut_err(i)), 32'(m_err[i]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                      input logic mr, input logic rdr, input logic rq, input logic rdy);
    @(posedge clk);
    #1;
    rs1 = s1; rs2 = s2; rd = d;
    memread = mr; redirect = rdr; req = rq; ready = rdy;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lit_ctrl(input string name, input logic [7:0] expv);
    chk({name, "_a"}, 32'(dut_ctrl(0)), 32'(expv));
    chk({name, "_b"}, 32'(dut_ctrl(1)), 32'(expv));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    rs1 = 0; rs2 = 0; rd = 0; memread = 0; redirect = 0; req = 0; ready = 0;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rs1 = 0; rs2 = 0; rd = 0; memread = 0; redirect = 0; req = 0; ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    lit_ctrl("reset_ctrl", 8'b0);
    chk("reset_cnt_a", dut_cnt(0), 0);
    chk("reset_err_b", 32'(dut_err(1)), 0);
    #1;
    rst = 1'b0;

    // lw x5 in E, rs1_d = x5: one bubble then clear
    step(5, 0, 5, 1, 0, 0, 0);
    lit_ctrl("lu_rs1", 8'b1100_0101);
    idle();
    lit_ctrl("lu_after", 8'b0);
    chk("lu_cnt_a", dut_cnt(0), 1);

    // match on rs2
    step(1, 7, 7, 1, 0, 0, 0);
    lit_ctrl("lu_rs2", 8'b1100_0101);
    // x0 never hazards
    step(0, 0, 0, 1, 0, 0, 0);
    lit_ctrl("lu_x0", 8'b0);
    // not a load
    step(3, 3, 3, 0, 0, 0, 0);
    lit_ctrl("no_load", 8'b0);
    // redirect beats load-use
    step(5, 0, 5, 1, 1, 0, 0);
    lit_ctrl("redir_lu", 8'b0000_1101);
    idle();
    chk("cnt_after_lu_a", dut_cnt(0), 2);
    // single-cycle memory access
    step(0, 0, 0, 0, 0, 1, 1);
    lit_ctrl("mem_fast", 8'b0);

    // 3 cycles not ready, then ready: 4 frozen cycles
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      lit_ctrl("mem_wait", 8'b1111_0010);
    end
    step(0, 0, 0, 0, 0, 1, 1);
    lit_ctrl("mem_done", 8'b1111_0010);
    idle();
    lit_ctrl("mem_exit", 8'b0);
    chk("mem_cnt_a", dut_cnt(0), 4);
    chk("mem_cnt_b_sat", dut_cnt(1), 3);

    // redirect held across the wait acts on the exit cycle
    step(0, 0, 0, 0, 1, 1, 0);
    lit_ctrl("redir_in_run_busy", 8'b1111_0010);
    step(0, 0, 0, 0, 1, 1, 0);
    lit_ctrl("redir_in_wait", 8'b1111_0010);
    step(0, 0, 0, 0, 1, 1, 1);
    lit_ctrl("redir_wait_done", 8'b1111_0010);
    step(0, 0, 0, 0, 1, 0, 0);
    lit_ctrl("redir_exit", 8'b0000_1101);
    idle();

    // timeout: ready withheld 10 cycles
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      if (k == 5) chk("tmo_err_c5", 32'(dut_err(1)), 0);
      if (k == 6) chk("tmo_err_c6", 32'(dut_err(1)), 1);
    end
    step(0, 0, 0, 0, 0, 1, 1);
    idle();
    chk("tmo_sticky_b", 32'(dut_err(1)), 1);
    chk("tmo_none_a", 32'(dut_err(0)), 0);
    chk("tmo_cnt_a", dut_cnt(0), 11);
    chk("tmo_cnt_b", dut_cnt(1), 3);

    // async reset in the middle of a wait
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    lit_ctrl("pre_arst", 8'b1111_0010);
    #2;
    rst = 1'b1;
    #1;
    lit_ctrl("arst_ctrl", 8'b0);
    chk("arst_cnt_a", dut_cnt(0), 0);
    chk("arst_cnt_b", dut_cnt(1), 0);
    chk("arst_err_b", 32'(dut_err(1)), 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    idle();
    lit_ctrl("post_arst", 8'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
